// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared definitions for the asynchronous FIFO pointer logic.
//   PTR_W  : default pointer width (includes the wrap bit)
//   FUNC_W : working width of the Gray helpers; narrower pointers are
//            zero-extended on the way in and truncated on the way out
//   gray2bin / bin2gray : exact inverse pair used by encoder and decoder
// -----------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int PTR_W  = 9;
    localparam int FUNC_W = 32;

    // Prefix XOR from the MSB. Zero-extended upper bits contribute nothing,
    // so the low bits are the decode of any narrower Gray value.
    function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
        logic [FUNC_W-1:0] b;
        b[FUNC_W-1] = g[FUNC_W-1];
        for (int i = FUNC_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Standard reflected binary encoding.
    function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/g2b_sync_if.sv
// -----------------------------------------------------------------------------
// g2b_sync_if
// Bundles the remote Gray pointer and the decoded, locally-timed results.
//   gray_in    : Gray pointer from the remote clock domain (asynchronous)
//   gray_sync  : last synchronizer stage
//   bin_out    : decoded binary pointer
//   delta      : bin_out advance since the previous sample, modulo 2^N
//   bin_valid  : pipeline holds only post-reset samples
//   step_err   : one-cycle pulse on an implausible advance
//   err_sticky : latched step_err, cleared only by reset
// master drives gray_in; slave is the decoder.
// -----------------------------------------------------------------------------
interface g2b_sync_if #(
    parameter int N = async_fifo_pkg::PTR_W
);
    logic [N-1:0] gray_in;
    logic [N-1:0] gray_sync;
    logic [N-1:0] bin_out;
    logic [N-1:0] delta;
    logic         bin_valid;
    logic         step_err;
    logic         err_sticky;

    modport master (
        output gray_in,
        input  gray_sync,
        input  bin_out,
        input  delta,
        input  bin_valid,
        input  step_err,
        input  err_sticky
    );

    modport slave (
        input  gray_in,
        output gray_sync,
        output bin_out,
        output delta,
        output bin_valid,
        output step_err,
        output err_sticky
    );
endinterface

// File: rtl/g2b_sync_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// WIDTH-bit, STAGES-deep flop chain for crossing into the clk domain.
// Plain wires between stages so stage 0 alone absorbs metastability.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous input
//   q     : last stage
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    // Shift path: each stage copies its predecessor unchanged.
    always_comb begin
        stage_d[0] = d;
        for (int k = 1; k < STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/g2b_sync.sv
// -----------------------------------------------------------------------------
// g2b_sync
// Receiving-side pointer decoder for the async FIFO: synchronizes a remote
// Gray pointer, decodes it to binary, reports the modular advance per cycle
// and flags advances larger than MAX_STEP (including backward moves).
//   clk   : local clock
//   rst_n : asynchronous active-low reset, clears all state
//   bus   : g2b_sync_if slave (gray_in in; gray_sync, bin_out, delta,
//           bin_valid, step_err, err_sticky out, all registered)
// Parameters: N pointer width, SYNC_STAGES 2..4, MAX_STEP 1..2^(N-1)-1.
// -----------------------------------------------------------------------------
module g2b_sync
    import async_fifo_pkg::*;
#(
    parameter int N           = PTR_W,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_STEP    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    g2b_sync_if.slave  bus
);

    // Fill counter just wide enough to reach SYNC_STAGES+1 and hold there.
    localparam int                CNT_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]  FILL_MAX = CNT_W'(SYNC_STAGES + 1);
    localparam logic [N-1:0]      STEP_LIM = N'(MAX_STEP);

    logic [N-1:0]     gray_sync_s;
    logic [N-1:0]     bin_dec_s;

    logic [N-1:0]     bin_out_q,    bin_out_d;
    logic [N-1:0]     delta_q,      delta_d;
    logic [CNT_W-1:0] fill_q,       fill_d;
    logic             valid_q,      valid_d;
    logic             pair_valid_q, pair_valid_d;
    logic             step_err_q,   step_err_d;
    logic             sticky_q,     sticky_d;

    sync_ff #(
        .WIDTH  (N),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.gray_in),
        .q     (gray_sync_s)
    );

    // Decode, advance, qualification and error next-state.
    always_comb begin
        bin_dec_s    = N'(gray2bin(FUNC_W'(gray_sync_s)));
        bin_out_d    = bin_dec_s;
        // Modular subtract: a wrap from all-ones to zero yields 1, a
        // backward move yields a large value.
        delta_d      = bin_dec_s - bin_out_q;

        if (fill_q != FILL_MAX) begin
            fill_d = fill_q + CNT_W'(1);
        end else begin
            fill_d = fill_q;
        end
        valid_d      = valid_q | (fill_d == FILL_MAX);

        // The delta being registered now pairs the sample leaving bin_out_q
        // (qualified by valid_q) with the one entering (qualified by valid_d).
        pair_valid_d = valid_q & valid_d;
        step_err_d   = pair_valid_q & (delta_q > STEP_LIM);
        sticky_d     = sticky_q | step_err_d;
    end

    // Output and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out_q    <= '0;
            delta_q      <= '0;
            fill_q       <= '0;
            valid_q      <= 1'b0;
            pair_valid_q <= 1'b0;
            step_err_q   <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            bin_out_q    <= bin_out_d;
            delta_q      <= delta_d;
            fill_q       <= fill_d;
            valid_q      <= valid_d;
            pair_valid_q <= pair_valid_d;
            step_err_q   <= step_err_d;
            sticky_q     <= sticky_d;
        end
    end

    assign bus.gray_sync  = gray_sync_s;
    assign bus.bin_out    = bin_out_q;
    assign bus.delta      = delta_q;
    assign bus.bin_valid  = valid_q;
    assign bus.step_err   = step_err_q;
    assign bus.err_sticky = sticky_q;

endmodule

// File: tb/tb_g2b_sync.sv
// -----------------------------------------------------------------------------
// tb_g2b_sync
// Directed scenarios plus a random pointer walk against a reference model
// that predicts each output from the history of applied pointers.
// -----------------------------------------------------------------------------
module tb_g2b_sync;
    import async_fifo_pkg::*;

    localparam int N    = 9;
    localparam int S    = 2;
    localparam int MAXS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    g2b_sync_if #(.N(N)) bus ();

    g2b_sync #(
        .N           (N),
        .SYNC_STAGES (S),
        .MAX_STEP    (MAXS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int           n_vec    = 0;
    int           n_err    = 0;
    logic [N-1:0] hist[$];       // gray value sampled at edge k+1 since release
    int           edges    = 0;  // clock edges since reset release
    bit           sticky_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Binary value whose Gray code is g: XOR of all right shifts of g.
    function automatic logic [N-1:0] num_of_gray(input logic [N-1:0] g);
        logic [N-1:0] b;
        b = g;
        for (int s = 1; s < N; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [N-1:0] m_gsync(input int e);
        if (e < S) return '0;
        return hist[e-S];
    endfunction

    function automatic logic [N-1:0] m_bin(input int e);
        if (e < S + 1) return '0;
        return num_of_gray(hist[e-S-1]);
    endfunction

    function automatic logic [N-1:0] m_delta(input int e);
        logic [N-1:0] d;
        if (e < 1) return '0;
        d = m_bin(e) - m_bin(e - 1);
        return d;
    endfunction

    // Flag after edge e judges the delta of edge e-1, whose two samples
    // (edges e-1 and e-2) must both be valid.
    function automatic bit m_step(input int e);
        if (e < S + 3) return 1'b0;
        return (32'(m_delta(e - 1)) > MAXS);
    endfunction

    task automatic check_all();
        bit st;
        st = m_step(edges);
        if (st) sticky_m = 1'b1;
        chk("gray_sync",  32'(bus.gray_sync),  32'(m_gsync(edges)));
        chk("bin_out",    32'(bus.bin_out),    32'(m_bin(edges)));
        chk("delta",      32'(bus.delta),      32'(m_delta(edges)));
        chk("bin_valid",  32'(bus.bin_valid),  (edges >= S + 1) ? 32'd1 : 32'd0);
        chk("step_err",   32'(bus.step_err),   st ? 32'd1 : 32'd0);
        chk("err_sticky", 32'(bus.err_sticky), sticky_m ? 32'd1 : 32'd0);
    endtask

    // Drive at negedge, sample at posedge+1.
    task automatic tick(input logic [N-1:0] g);
        @(negedge clk);
        bus.gray_in = g;
        @(posedge clk);
        if (rst_n) begin
            hist.push_back(g);
            edges++;
        end
        #1;
        check_all();
    endtask

    task automatic tick_bin(input logic [N-1:0] b);
        logic [FUNC_W-1:0] gw;
        gw = bin2gray(FUNC_W'(b));
        tick(gw[N-1:0]);
    endtask

    task automatic hold(input logic [N-1:0] g, input int n);
        for (int i = 0; i < n; i++) tick(g);
    endtask

    // Called at posedge+1: assert mid-cycle, check immediate clear, release mid-cycle.
    task automatic reset_pulse(input logic [N-1:0] g_during);
        #2;
        rst_n = 1'b0;
        #1;
        hist.delete();
        edges    = 0;
        sticky_m = 1'b0;
        check_all();
        tick(g_during);
        #2;
        rst_n = 1'b1;
    endtask

    logic [N-1:0] cur;
    int           r;

    initial begin
        bus.gray_in = '0;
        rst_n       = 1'b0;
        tick(9'h000);
        tick(9'h000);
        #2;
        rst_n = 1'b1;

        // 1: reset release with zero input
        tick(9'h000);
        tick(9'h000);
        chk("t1_valid_e2", 32'(bus.bin_valid), 32'd0);
        tick(9'h000);
        chk("t1_valid_e3", 32'(bus.bin_valid), 32'd1);
        chk("t1_bin_zero", 32'(bus.bin_out),   32'd0);

        // 2: static decode, visible 3 edges after apply
        hold(9'h140, 3);
        chk("t2_140", 32'(bus.bin_out), 32'h180);
        hold(9'h007, 3);
        chk("t2_007", 32'(bus.bin_out), 32'h005);
        hold(9'h100, 3);
        chk("t2_100", 32'(bus.bin_out), 32'h1FF);

        // 3: wrap 0x1FF -> 0 is a step of one
        reset_pulse(9'h000);
        hold(9'h100, 6);
        hold(9'h000, 3);
        chk("t3_wrap_bin",   32'(bus.bin_out),    32'h000);
        chk("t3_wrap_delta", 32'(bus.delta),      32'd1);
        tick(9'h000);
        chk("t3_no_err",     32'(bus.step_err),   32'd0);
        chk("t3_no_sticky",  32'(bus.err_sticky), 32'd0);

        // 4: burst 10 -> 16
        reset_pulse(9'h000);
        hold(9'h00F, 6);
        hold(9'h018, 3);
        chk("t4_bin",   32'(bus.bin_out), 32'd16);
        chk("t4_delta", 32'(bus.delta),   32'd6);
        tick(9'h018);
        chk("t4_err",    32'(bus.step_err),   32'd1);
        chk("t4_sticky", 32'(bus.err_sticky), 32'd1);
        tick(9'h018);
        chk("t4_err_pulse", 32'(bus.step_err), 32'd0);
        hold(9'h018, 3);
        chk("t4_sticky_hold", 32'(bus.err_sticky), 32'd1);

        // 5: backward 20 -> 19
        hold(9'h01E, 5);
        hold(9'h01A, 3);
        chk("t5_delta", 32'(bus.delta), 32'h1FF);
        tick(9'h01A);
        chk("t5_err", 32'(bus.step_err), 32'd1);

        // 6: reset during an increment stream
        reset_pulse(9'h000);
        cur = 9'd100;
        for (int i = 0; i < 8; i++) begin
            tick_bin(cur);
            cur = cur + 9'd1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_bin",   32'(bus.bin_out),   32'd0);
        chk("t6_async_delta", 32'(bus.delta),     32'd0);
        chk("t6_async_gsync", 32'(bus.gray_sync), 32'd0);
        chk("t6_async_valid", 32'(bus.bin_valid), 32'd0);
        hist.delete();
        edges    = 0;
        sticky_m = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick_bin(cur);
            cur = cur + 9'd1;
        end
        #2;
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick_bin(cur);
            cur = cur + 9'd1;
            if (i <= S) chk("t6_valid_low", 32'(bus.bin_valid), 32'd0);
            if (i == S + 1) chk("t6_valid_high", 32'(bus.bin_valid), 32'd1);
            if (i > S + 1) chk("t6_no_spurious", 32'(bus.step_err), 32'd0);
        end

        // Random walk: mostly legal advances, some jumps, backward steps, resets
        reset_pulse(9'h000);
        cur = '0;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                cur = N'($urandom);
            end else if (r < 6) begin
                cur = cur - 9'd1;
            end else begin
                cur = cur + N'($urandom_range(0, MAXS));
            end
            if (r == 99) reset_pulse(cur);
            tick_bin(cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/g2b_sync.md
# g2b_sync

Receiving-side pointer decoder for the async FIFO. It takes a Gray-coded pointer launched from the opposite clock domain, synchronizes it into the local `clk` domain and converts it back to binary. It also reports the modular advance since the previous sample and flags implausible jumps. One instance sits in each domain: the read side decodes the write pointer for empty/occupancy, and the write side decodes the read pointer for full.

## Interface
Parameters:
- `N`, 9, pointer width in bits. Includes the wrap bit.
- `SYNC_STAGES`, 2, number of synchronizer flops. Legal values are 2 to 4.
- `MAX_STEP`, 4, largest legal per-cycle advance. Range is 1 to 2^(N-1)-1.

Ports:
- `clk` input 1: local domain clock.
- `rst_n` input 1: asynchronous assert, active-low reset.
- `gray_in` input N: Gray pointer from the remote domain. It is asynchronous to `clk`.
- `gray_sync` output N: last synchronizer stage, registered.
- `bin_out` output N: decoded binary pointer, registered.
- `delta` output N: `bin_out` minus its previous value, modulo 2^N, registered.
- `bin_valid` output 1: pipeline holds only post-reset samples.
- `step_err` output 1: one-cycle pulse when `delta > MAX_STEP` while valid.
- `err_sticky` output 1: set by `step_err`, cleared only by reset.

## Operation
- Synchronizer: `sync[0] <= gray_in`, and `sync[k] <= sync[k-1]`. `gray_sync = sync[SYNC_STAGES-1]`. No logic is allowed between synchronizer stages.
- Decode is combinational from `gray_sync`:
  - `b[N-1] = g[N-1]`
  - `b[i] = b[i+1] ^ g[i]` for i = N-2 down to 0.
  - This is a prefix XOR from the MSB, and is the exact inverse of the FIFO's binary-to-Gray encoder.
- Output register `bin_out <= decode(gray_sync)` every cycle. There is no enable.
- `delta <= decode(gray_sync) - bin_out`, truncated to N bits. Wrap from 2^N-1 to 0 therefore yields 1.
- Fill counter:
  - Width is clog2(SYNC_STAGES+2).
  - Counts clock edges after reset release and saturates.
  - `bin_valid` asserts when the count reaches SYNC_STAGES+1 and stays high until reset.
- Error check:
  - `step_err` is registered.
  - It asserts in the cycle after `delta` exceeds `MAX_STEP`, and only if `bin_valid` was high for both samples that form that delta.
  - A backward move appears as a large modular delta and is flagged.
- Reset, asynchronous:
  - All sync stages, `bin_out`, `delta`, the fill counter, `step_err`, `err_sticky` and `bin_valid` go to 0.
  - Gray 0 decodes to binary 0, so the outputs stay self-consistent.
- Reset mid-operation: all state clears immediately. `bin_valid` re-qualifies only after SYNC_STAGES+1 further edges.

## Timing
- Latency from the first sampling edge to `bin_out`, `delta` and `gray_sync`:
  - `gray_sync` after SYNC_STAGES edges.
  - `bin_out` and `delta` after SYNC_STAGES+1 edges.
  - With defaults this is 3 edges.
- `step_err` lags `delta` by one edge. `err_sticky` rises on the same edge as `step_err`.
- Throughput is one new sample per cycle. A stable input is decoded to a constant value with `delta = 0`.
- Metastability is absorbed in `sync[0]`. A sample taken while `gray_in` toggles resolves to either the old or the new pointer value, never a third value.
- The critical path is N-1 XORs plus an N-bit subtract, and must close at the FIFO's clock target.

## Structure
- Shared package `async_fifo_pkg` holds:
  - the default pointer width constant;
  - the `gray2bin` function;
  - the matching `bin2gray` function, used by the bench model.
- One sub-module is natural: `sync_ff`, a parameterized N-bit, SYNC_STAGES-deep flop chain with async active-low reset. It is reused for the reset and flag synchronizers elsewhere in the FIFO.

## Test plan
1. Hold `gray_in=0` and release `rst_n`. Required: `bin_valid` rises at edge 3, `bin_out=0`, `delta=0`, no `step_err`.
2. Static decode. Apply `gray_in=9'h140`, then `9'h007`, then `9'h100`. Required: `bin_out` shows `9'h180`, `9'h005`, `9'h1FF`, each 3 edges after its apply.
3. Wrap. Gray sequence 0x100 → 0x000 on consecutive cycles. Required: `bin_out` 0x1FF → 0x000, `delta=1`, no error.
4. Burst. Jump binary 10 to 16 (gray 0x00F → 0x018) in one cycle. Required: `delta=6`, `step_err` pulses for 1 cycle, `err_sticky=1` until reset.
5. Backward move. Binary 20 → 19. Required: `delta=9'h1FF`, `step_err` asserted.
6. Reset pulse while a stream of increments is running. Required:
   - all outputs are 0 in the same cycle as the reset edge, without waiting for `clk`;
   - `bin_valid` stays low for 3 edges after release;
   - no spurious `step_err` on the first valid sample.
